// File: rtl/mac9_responder.sv
// rtl/mac9_responder.sv - 9-tap signed dot-product responder with saturation
//
// Samples nine signed weight/pixel pairs on each go strobe and returns their
// saturated dot product on Y1 after LATENCY clocks (1 or 2). Y1 holds between
// results.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   go         request strobe, operands valid in the same cycle
//   clr_stat   clears ovf and op_cnt
//   w11..w19   signed weights, SIZE bits each
//   p11..p19   signed pixels, SIZE bits each
//   Y1         signed saturated dot product, 2*SIZE-1 bits
//   y_valid    one-clock pulse in the first cycle Y1 shows a new result
//   ovf        sticky saturation flag
//   op_cnt     accepted-request counter, wraps

module mac9_responder #(
  parameter int SIZE    = 11,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic                     clr_stat,
  input  logic signed [SIZE-1:0]   w11,
  input  logic signed [SIZE-1:0]   w12,
  input  logic signed [SIZE-1:0]   w13,
  input  logic signed [SIZE-1:0]   w14,
  input  logic signed [SIZE-1:0]   w15,
  input  logic signed [SIZE-1:0]   w16,
  input  logic signed [SIZE-1:0]   w17,
  input  logic signed [SIZE-1:0]   w18,
  input  logic signed [SIZE-1:0]   w19,
  input  logic signed [SIZE-1:0]   p11,
  input  logic signed [SIZE-1:0]   p12,
  input  logic signed [SIZE-1:0]   p13,
  input  logic signed [SIZE-1:0]   p14,
  input  logic signed [SIZE-1:0]   p15,
  input  logic signed [SIZE-1:0]   p16,
  input  logic signed [SIZE-1:0]   p17,
  input  logic signed [SIZE-1:0]   p18,
  input  logic signed [SIZE-1:0]   p19,
  output logic signed [2*SIZE-2:0] Y1,
  output logic                     y_valid,
  output logic                     ovf,
  output logic [CNT_W-1:0]         op_cnt
);

  localparam int PW = 2 * SIZE;      // full product width
  localparam int SW = 2 * SIZE + 4;  // accumulation width, headroom for 9 terms
  localparam int YW = 2 * SIZE - 1;  // result width

  logic signed [SIZE-1:0] w_a [9];
  logic signed [SIZE-1:0] p_a [9];
  logic signed [PW-1:0]   prod [9];
  logic signed [PW-1:0]   sum_in [9];
  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   max_s;
  logic signed [SW-1:0]   min_s;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [YW-1:0]          sat_val;
  logic                   res_en;

  assign w_a[0] = w11;
  assign w_a[1] = w12;
  assign w_a[2] = w13;
  assign w_a[3] = w14;
  assign w_a[4] = w15;
  assign w_a[5] = w16;
  assign w_a[6] = w17;
  assign w_a[7] = w18;
  assign w_a[8] = w19;
  assign p_a[0] = p11;
  assign p_a[1] = p12;
  assign p_a[2] = p13;
  assign p_a[3] = p14;
  assign p_a[4] = p15;
  assign p_a[5] = p16;
  assign p_a[6] = p17;
  assign p_a[7] = p18;
  assign p_a[8] = p19;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod[k] = PW'(w_a[k]) * PW'(p_a[k]);
    end
  end

  // Result-range limits expressed at accumulator width.
  assign max_s = {{(SW-YW+1){1'b0}}, {(YW-1){1'b1}}};
  assign min_s = {{(SW-YW+1){1'b1}}, {(YW-1){1'b0}}};

  generate
    if (LATENCY == 1) begin : g_lat1
      assign res_en = go;
      always_comb begin
        for (int k = 0; k < 9; k++) begin
          sum_in[k] = prod[k];
        end
      end
    end else begin : g_lat2
      logic                 v1;
      logic signed [PW-1:0] prod_q [9];

      // Products are captured only on go so idle (possibly X) operands never
      // enter the pipeline.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v1 <= 1'b0;
          for (int k = 0; k < 9; k++) begin
            prod_q[k] <= '0;
          end
        end else begin
          v1 <= go;
          if (go) begin
            for (int k = 0; k < 9; k++) begin
              prod_q[k] <= prod[k];
            end
          end
        end
      end

      assign res_en = v1;
      always_comb begin
        for (int k = 0; k < 9; k++) begin
          sum_in[k] = prod_q[k];
        end
      end
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) begin
      sum = sum + {{(SW-PW){sum_in[k][PW-1]}}, sum_in[k]};
    end
  end

  assign sat_hi  = (sum > max_s);
  assign sat_lo  = (sum < min_s);
  assign sat_val = sat_hi ? max_s[YW-1:0] :
                   sat_lo ? min_s[YW-1:0] : sum[YW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y1      <= '0;
      y_valid <= 1'b0;
      ovf     <= 1'b0;
      op_cnt  <= '0;
    end else begin
      y_valid <= res_en;
      if (res_en) begin
        Y1 <= sat_val;
      end

      // A saturation in the same edge as clr_stat leaves ovf set.
      if (res_en && (sat_hi || sat_lo)) begin
        ovf <= 1'b1;
      end else if (clr_stat) begin
        ovf <= 1'b0;
      end

      if (clr_stat) begin
        op_cnt <= go ? CNT_W'(1) : '0;
      end else if (go) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac9_responder.sv
// tb/tb_mac9_responder.sv - scoreboard bench for mac9_responder at latency 1 and 2

module tb_mac9_responder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               go;
  logic               clr_stat;
  logic signed [10:0] w [9];
  logic signed [10:0] p [9];

  logic signed [20:0] d1_y, d2_y;
  logic               d1_vld, d2_vld, d1_ovf, d2_ovf;
  logic [15:0]        d1_cnt;
  logic [3:0]         d2_cnt;

  int     wi [9];
  int     pi [9];
  longint q1 [$];
  longint q2 [$];
  int     ncmp = 0;
  int     nerr = 0;

  always #5 clk = ~clk;

  mac9_responder #(.SIZE(11), .LATENCY(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .go(go), .clr_stat(clr_stat),
    .w11(w[0]), .w12(w[1]), .w13(w[2]), .w14(w[3]), .w15(w[4]),
    .w16(w[5]), .w17(w[6]), .w18(w[7]), .w19(w[8]),
    .p11(p[0]), .p12(p[1]), .p13(p[2]), .p14(p[3]), .p15(p[4]),
    .p16(p[5]), .p17(p[6]), .p18(p[7]), .p19(p[8]),
    .Y1(d1_y), .y_valid(d1_vld), .ovf(d1_ovf), .op_cnt(d1_cnt)
  );

  mac9_responder #(.SIZE(11), .LATENCY(2), .CNT_W(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .go(go), .clr_stat(clr_stat),
    .w11(w[0]), .w12(w[1]), .w13(w[2]), .w14(w[3]), .w15(w[4]),
    .w16(w[5]), .w17(w[6]), .w18(w[7]), .w19(w[8]),
    .p11(p[0]), .p12(p[1]), .p13(p[2]), .p14(p[3]), .p15(p[4]),
    .p16(p[5]), .p17(p[6]), .p18(p[7]), .p19(p[8]),
    .Y1(d2_y), .y_valid(d2_vld), .ovf(d2_ovf), .op_cnt(d2_cnt)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int wv, input int pv);
    for (int k = 0; k < 9; k++) begin
      wi[k] = wv;
      pi[k] = pv;
    end
  endtask

  // Reference: exact integer dot product clamped to the 21-bit signed range.
  task automatic issue(input bit to_d2);
    longint s;
    longint e;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      s += longint'(wi[k]) * longint'(pi[k]);
      w[k] = 11'(wi[k]);
      p[k] = 11'(pi[k]);
    end
    e = (s > 1048575) ? 1048575 : ((s < -1048576) ? -1048576 : s);
    q1.push_back(e);
    if (to_d2) q2.push_back(e);
    go = 1'b1;
  endtask

  task automatic idle();
    go = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w[k] = 'x;
      p[k] = 'x;
    end
  endtask

  // Scoreboard: every y_valid pops the oldest expected result of that instance.
  always @(negedge clk) begin
    if (d1_vld === 1'b1) begin
      if (q1.size() == 0) begin
        ncmp++;
        nerr++;
        $error("FAIL d1_unexpected_valid: observed Y1 %0d expected no result", d1_y);
      end else begin
        chk("d1_result", d1_y, q1.pop_front());
      end
    end
    if (d2_vld === 1'b1) begin
      if (q2.size() == 0) begin
        ncmp++;
        nerr++;
        $error("FAIL d2_unexpected_valid: observed Y1 %0d expected no result", d2_y);
      end else begin
        chk("d2_result", d2_y, q2.pop_front());
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    clr_stat = 1'b0;
    idle();

    // Reset held two clocks while go toggles.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("rst_d1_y", d1_y, 0);
    chk("rst_d2_y", d2_y, 0);
    chk("rst_d1_vld", d1_vld, 0);
    chk("rst_d2_vld", d2_vld, 0);
    chk("rst_d1_ovf", d1_ovf, 0);
    chk("rst_d2_ovf", d2_ovf, 0);
    chk("rst_d1_cnt", d1_cnt, 0);
    chk("rst_d2_cnt", d2_cnt, 0);
    rst_n = 1'b1;
    tick();

    // 9 * 3 * 5 = 135; latency 1 then 2.
    set_all(3, 5);
    issue(1);
    tick();
    idle();
    chk("b_d1_vld", d1_vld, 1);
    chk("b_d1_y", d1_y, 135);
    chk("b_d1_cnt", d1_cnt, 1);
    chk("b_d2_vld_early", d2_vld, 0);
    chk("b_d2_cnt", d2_cnt, 1);
    tick();
    chk("b_d1_vld_drop", d1_vld, 0);
    chk("b_d1_y_hold", d1_y, 135);
    chk("b_d2_vld", d2_vld, 1);
    chk("b_d2_y", d2_y, 135);

    // Mixed signs inside range: -1024 * 1023 on one tap.
    set_all(0, 0);
    wi[0] = -1024;
    pi[0] = 1023;
    issue(1);
    tick();
    idle();
    tick();
    chk("c_d1_y", d1_y, -1047552);
    chk("c_d2_y", d2_y, -1047552);
    chk("c_d1_ovf", d1_ovf, 0);
    chk("c_d2_ovf", d2_ovf, 0);

    // Mixed signs on all taps: 9 * -1047552 is below -2^20, so it clamps.
    set_all(-1024, 1023);
    issue(1);
    tick();
    idle();
    chk("d_d1_y", d1_y, -1048576);
    chk("d_d1_ovf", d1_ovf, 1);
    chk("d_d2_ovf_early", d2_ovf, 0);
    tick();
    chk("d_d2_y", d2_y, -1048576);
    chk("d_d2_ovf", d2_ovf, 1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("d_clr_d1_ovf", d1_ovf, 0);
    chk("d_clr_d2_ovf", d2_ovf, 0);
    chk("d_clr_d1_cnt", d1_cnt, 0);
    chk("d_clr_d2_cnt", d2_cnt, 0);
    chk("d_clr_d1_y_hold", d1_y, -1048576);
    chk("d_clr_d2_y_hold", d2_y, -1048576);

    // Positive saturation: 9 * 1048576 clamps to 2^20-1.
    set_all(-1024, -1024);
    issue(1);
    tick();
    idle();
    tick();
    chk("e_d1_y", d1_y, 1048575);
    chk("e_d2_y", d2_y, 1048575);
    chk("e_d1_ovf", d1_ovf, 1);
    chk("e_d2_ovf", d2_ovf, 1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("e_clr_d1_ovf", d1_ovf, 0);
    chk("e_clr_d2_ovf", d2_ovf, 0);
    chk("e_clr_d1_y_hold", d1_y, 1048575);
    chk("e_clr_d2_y_hold", d2_y, 1048575);

    // clr_stat together with go leaves op_cnt at 1.
    set_all(1, 1);
    clr_stat = 1'b1;
    issue(1);
    tick();
    clr_stat = 1'b0;
    idle();
    chk("f_d1_cnt", d1_cnt, 1);
    chk("f_d2_cnt", d2_cnt, 1);
    chk("f_d1_y", d1_y, 9);
    tick();

    // clr_stat coinciding with a saturation leaves ovf set.
    set_all(-1024, -1024);
    clr_stat = 1'b1;
    issue(1);
    tick();
    idle();
    chk("g_d1_ovf_wins", d1_ovf, 1);
    chk("g_d2_ovf_cleared", d2_ovf, 0);
    tick();
    clr_stat = 1'b0;
    chk("g_d1_ovf_cleared", d1_ovf, 0);
    chk("g_d2_ovf_wins", d2_ovf, 1);

    // Back-to-back requests, w=1, p=k: 9, 18, 27, 36.
    set_all(1, 0);
    for (int i = 1; i <= 4; i++) begin
      for (int k = 0; k < 9; k++) pi[k] = i;
      issue(1);
      tick();
      chk("h_d1_y", d1_y, 9 * i);
      chk("h_d1_vld", d1_vld, 1);
      if (i > 1) begin
        chk("h_d2_y", d2_y, 9 * (i - 1));
        chk("h_d2_vld", d2_vld, 1);
      end
    end
    idle();
    tick();
    chk("h_d2_y_last", d2_y, 36);
    chk("h_d2_vld_last", d2_vld, 1);
    chk("h_d1_vld_drop", d1_vld, 0);
    tick();
    chk("h_d2_vld_drop", d2_vld, 0);

    // op_cnt wrap: 17 requests after a clear; the 4-bit counter wraps to 1.
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    set_all(0, 0);
    for (int i = 0; i < 17; i++) begin
      issue(1);
      tick();
    end
    idle();
    chk("i_d1_cnt", d1_cnt, 17);
    chk("i_d2_cnt", d2_cnt, 1);
    tick();

    // Reset with a latency-2 request in flight: no result may follow.
    set_all(2, 2);
    issue(0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("j_d1_y", d1_y, 0);
    chk("j_d2_y", d2_y, 0);
    chk("j_d1_vld", d1_vld, 0);
    chk("j_d2_vld", d2_vld, 0);
    chk("j_d1_cnt", d1_cnt, 0);
    chk("j_d2_ovf", d2_ovf, 0);
    tick();
    chk("j_d2_vld_after", d2_vld, 0);
    chk("j_d2_y_after", d2_y, 0);
    tick();

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
